// File: rtl/param_data_buffer.sv
// Single-port circular data buffer shared by the USB receive/transmit paths and the host bus.
// Writes: rx side has priority over tx side. Reads: tx_packet_data has priority over rx_data.
module param_data_buffer #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 64,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_rx_packet_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              get_rx_data,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [CNT_W-1:0]  buffer_occupancy,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              write_conflict
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] rx_data_q, tx_pkt_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wcf_q, wcf_d;

  logic              drop_all;
  logic              rd_req, wr_req;
  logic              rd_acc, wr_acc;
  logic              full_w;
  logic [DATA_W-1:0] wr_word;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    drop_all = clear | flush;
    rd_req   = get_tx_packet_data | get_rx_data;
    wr_req   = store_rx_packet_data | store_tx_data;
    full_w   = (occ_q == CNT_W'(DEPTH));
    // No read-through-empty bypass; a full buffer accepts a write only alongside a read.
    rd_acc   = rd_req & ~drop_all & (occ_q != '0);
    wr_acc   = wr_req & ~drop_all & (~full_w | rd_acc);
    wr_word  = store_rx_packet_data ? rx_packet_data : tx_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wcf_d    = wcf_q;

    if (drop_all) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      if (clear) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        wcf_d = 1'b0;
      end
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({wr_acc, rd_acc})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
      if (wr_req && !wr_acc)                        ovf_d = 1'b1;
      if (rd_req && !rd_acc)                        unf_d = 1'b1;
      if (store_rx_packet_data && store_tx_data)    wcf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rx_data_q <= '0;
      tx_pkt_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      wcf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wcf_q    <= wcf_d;
      // The read that loses arbitration leaves its output untouched.
      if (rd_acc && get_tx_packet_data) tx_pkt_q  <= mem_q[rd_ptr_q];
      else if (rd_acc)                  rx_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_word;
  end

  assign rx_data          = rx_data_q;
  assign tx_packet_data   = tx_pkt_q;
  assign buffer_occupancy = occ_q;
  assign empty            = (occ_q == '0);
  assign full             = full_w;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;
  assign write_conflict   = wcf_q;

endmodule

// File: doc/param_data_buffer.md
PARAM_DATA_BUFFER -- requirements
Module: param_data_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning storage entries; legal range 2..256, any integer.
REQ-003 SHALL have derived localparam PTR_W = clog2(DEPTH) and CNT_W = clog2(DEPTH+1).
REQ-004 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  in  1  empty buffer and clear error flags.
REQ-007 SHALL have port flush  in  1  empty buffer; error flags kept.
REQ-008 SHALL have port store_rx_packet_data  in  1  write rx_packet_data this cycle.
REQ-009 SHALL have port rx_packet_data  in  DATA_W  write data from USB receiver.
REQ-010 SHALL have port store_tx_data  in  1  write tx_data this cycle.
REQ-011 SHALL have port tx_data  in  DATA_W  write data from host bus side.
REQ-012 SHALL have port get_rx_data  in  1  read one word to rx_data.
REQ-013 SHALL have port get_tx_packet_data  in  1  read one word to tx_packet_data.
REQ-014 SHALL have port rx_data  out  DATA_W  registered read word, host side.
REQ-015 SHALL have port tx_packet_data  out  DATA_W  registered read word, USB transmitter side.
REQ-016 SHALL have port buffer_occupancy  out  CNT_W  number of stored words.
REQ-017 SHALL have ports empty, full  out  1 each  occupancy==0, occupancy==DEPTH.
REQ-018 SHALL have ports overflow, underflow  out  1 each  sticky error flags.
REQ-019 SHALL have port write_conflict  out  1  sticky; both store inputs seen in one cycle.

Function
REQ-020 SHALL implement circular storage of DEPTH words with write pointer, read pointer (PTR_W bits) and occupancy counter.
REQ-021 SHALL arbitrate writes: store_rx_packet_data beats store_tx_data; both high -> rx word written, tx word dropped, write_conflict set.
REQ-022 SHALL arbitrate reads: get_tx_packet_data beats get_rx_data; loser ignored, its output held, no flag.
REQ-023 SHALL accept a read only when occupancy>0; accepted read loads entry[rd_ptr] into the selected output on the same edge (data visible 1 cycle after request), increments rd_ptr.
REQ-024 SHALL hold rx_data and tx_packet_data between their own accepted reads.
REQ-025 SHALL accept a write when occupancy<DEPTH, or when full with an accepted read in the same cycle; stores at wr_ptr, increments wr_ptr.
REQ-026 SHALL wrap each pointer from DEPTH-1 to 0 (modulo DEPTH, including non-power-of-two DEPTH).
REQ-027 SHALL update occupancy: +1 write only, -1 read only, unchanged for both or neither.
REQ-028 SHALL not bypass: read request while empty with simultaneous write -> read rejected, write accepted.
REQ-029 SHALL set overflow on a rejected write, underflow on a rejected read; flags sticky until clear or reset.
REQ-030 SHALL treat clear/flush as synchronous, highest priority: pointers and occupancy to 0 next edge, all reads/writes that cycle ignored, rx_data/tx_packet_data held.
REQ-031 SHALL clear overflow, underflow, write_conflict on clear; flush SHALL leave them unchanged; clear+flush together behaves as clear.
REQ-032 SHALL drive empty, full combinationally from registered occupancy.

Reset
REQ-033 SHALL on n_rst low, asynchronously: pointers 0, occupancy 0, rx_data 0, tx_packet_data 0, overflow/underflow/write_conflict 0, empty 1, full 0.
REQ-034 SHALL not require reset of storage array contents; reset mid-operation discards all stored words.

Verification
REQ-035 Reset, DATA_W=8, DEPTH=4: write 0xA1,0xB2 via store_tx_data, then get_rx_data x2 -> rx_data 0xA1 then 0xB2 one cycle after each request, empty=1 after.
REQ-036 Fill DEPTH=4 then one more write 0x55 -> full=1, overflow=1, occupancy 4; read all four -> original data order, 0x55 absent.
REQ-037 Full, simultaneous store_rx_packet_data(0x77)+get_tx_packet_data -> occupancy stays 4, oldest word on tx_packet_data, 0x77 later read last; wr_ptr/rd_ptr wrap correctly over 3 passes, DEPTH=5 also.
REQ-038 Both store inputs high (rx 0x11, tx 0x22) -> only 0x11 stored, write_conflict=1; get_rx_data while empty -> underflow=1, rx_data held.
REQ-039 Flush with 3 words and flags set -> occupancy 0, empty 1, flags kept; then clear -> flags 0; n_rst pulse mid-stream -> all outputs at REQ-033 values immediately.
